// File: rtl/alu_result_buf.sv
// alu_result_buf
//   Small circular FIFO that holds logic-unit results between the execute
//   stage and register writeback. Each entry stores the 32-bit result, its
//   destination tag, a zero flag and (optionally) an even-parity bit, all
//   computed when the entry is pushed. Head outputs come straight from
//   storage and read as zero whenever the buffer is empty.
//
// Optional feature macro: ALU_RESULT_PARITY_EN
//   defined   -> parity = XOR of in_z is stored and driven on out_par
//   undefined -> no parity storage, out_par tied to 0
//
// Parameters
//   DEPTH      number of entries (2, 4 or 8)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous discard of all entries (overrides push/pop)
//   in_valid   upstream result valid
//   in_ready   buffer can accept a result (not full, out of reset)
//   in_z       result, [0:31], bit 0 = MSB
//   in_dest    destination tag, [0:4]
//   out_valid  head entry valid
//   out_ready  writeback consumes head entry
//   out_z      head result (0 when empty)
//   out_dest   head destination tag (0 when empty)
//   out_zero   head result is all zeros (0 when empty)
//   out_par    head even-parity bit (0 when empty or parity disabled)
//   count      occupied entries, 0..DEPTH
module alu_result_buf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] in_z,
  input  logic [0:4]  in_dest,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] out_z,
  output logic [0:4]  out_dest,
  output logic        out_zero,
  output logic        out_par,
  output logic [3:0]  count
);

  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       cnt;
  logic             ready_en;
  logic             push;
  logic             pop;

  logic [0:31] z_mem    [DEPTH];
  logic [0:4]  dest_mem [DEPTH];
  logic        zero_mem [DEPTH];
`ifdef ALU_RESULT_PARITY_EN
  logic        par_mem  [DEPTH];
`endif

  function automatic logic is_zero(input logic [0:31] z);
    return (z == '0);
  endfunction

`ifdef ALU_RESULT_PARITY_EN
  function automatic logic even_par(input logic [0:31] z);
    return ^z;
  endfunction
`endif

  // Explicit wrap keeps the pointer correct even if DEPTH and the pointer
  // width ever stop being an exact power-of-two match.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ready_en is cleared by reset and set by the first clock edge after it,
  // so in_ready stays low during reset and rises one edge later.
  assign in_ready  = ready_en && (cnt < DEPTH_C);
  assign out_valid = (cnt != 4'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  // ---- control state: pointers and occupancy ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= 4'd0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= 4'd0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        case ({push, pop})
          2'b10:   cnt <= cnt + 4'd1;
          2'b01:   cnt <= cnt - 4'd1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // ---- entry storage: flags derived from in_z at push time ----
  // A write during flush lands in a slot that is then considered empty,
  // so it needs no extra gating.
  always_ff @(posedge clk) begin
    if (push) begin
      z_mem[wr_ptr]    <= in_z;
      dest_mem[wr_ptr] <= in_dest;
      zero_mem[wr_ptr] <= is_zero(in_z);
`ifdef ALU_RESULT_PARITY_EN
      par_mem[wr_ptr]  <= even_par(in_z);
`endif
    end
  end

  // ---- head read: gated by occupancy so an empty buffer reads as zero ----
  assign out_z    = out_valid ? z_mem[rd_ptr]    : '0;
  assign out_dest = out_valid ? dest_mem[rd_ptr] : '0;
  assign out_zero = out_valid ? zero_mem[rd_ptr] : 1'b0;
`ifdef ALU_RESULT_PARITY_EN
  assign out_par  = out_valid ? par_mem[rd_ptr]  : 1'b0;
`else
  assign out_par  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buf.sv
// Scoreboard bench for alu_result_buf. The driver issues one transaction per
// cycle just after the rising edge and queues the expected entry whenever the
// reference model says it will be accepted. The monitor samples on the
// falling edge, compares the head against the queue front and retires it on
// a pop.
module tb_alu_result_buf;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] z;
    logic [4:0]  dest;
    logic        zero;
    logic        par;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] in_z;
  logic [0:4]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] out_z;
  logic [0:4]  out_dest;
  logic        out_zero;
  logic        out_par;
  logic [3:0]  count;

  ent_t q[$];
  int   exp_now;
  bit   rdy_exp;
  int   n_cmp;
  int   n_err;

  alu_result_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_dest  (out_dest),
    .out_zero  (out_zero),
    .out_par   (out_par),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk_ent(input logic [31:0] z, input logic [4:0] d);
    ent_t e;
    e.z    = z;
    e.dest = d;
    e.zero = (z == 32'd0);
`ifdef ALU_RESULT_PARITY_EN
    e.par  = ($countones(z) % 2) == 1;
`else
    e.par  = 1'b0;
`endif
    return e;
  endfunction

  // One clock cycle of stimulus, issued 1 time unit after the rising edge.
  task automatic cycle(input bit v, input logic [31:0] z, input logic [4:0] d,
                       input bit rdy, input bit fl);
    @(posedge clk);
    #1;
    rdy_exp   = 1'b1;
    exp_now   = q.size();
    in_valid  = v;
    in_z      = z;
    in_dest   = d;
    out_ready = rdy;
    flush     = fl;
    if (v && !fl && exp_now < DEPTH) q.push_back(mk_ent(z, d));
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_z      = '0;
    in_dest   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // Assert reset for two edges, then release it between edges.
  task automatic do_reset();
    q.delete();
    exp_now = 0;
    rdy_exp = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: falling-edge sampling of every output.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_z",     32'(out_z),     32'd0);
      chk("rst_out_par",   32'(out_par),   32'd0);
    end else begin
      chk("count",     32'(count),     32'(exp_now));
      chk("in_ready",  32'(in_ready),  32'(rdy_exp && exp_now < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_now != 0));
      if (exp_now != 0 && q.size() > 0) begin
        chk("out_z",    32'(out_z),    q[0].z);
        chk("out_dest", 32'(out_dest), 32'(q[0].dest));
        chk("out_zero", 32'(out_zero), 32'(q[0].zero));
        chk("out_par",  32'(out_par),  32'(q[0].par));
        if (out_ready && !flush) void'(q.pop_front());
      end else if (exp_now == 0) begin
        chk("empty_out_z",    32'(out_z),    32'd0);
        chk("empty_out_dest", 32'(out_dest), 32'd0);
        chk("empty_out_zero", 32'(out_zero), 32'd0);
        chk("empty_out_par",  32'(out_par),  32'd0);
      end
      if (flush) q.delete();
    end
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_now = 0;
    rdy_exp = 1'b0;
    rst_n   = 1'b1;
    idle_inputs();
    #2;
    do_reset();

    // Single push of all-ones, then a zero result and a result with odd parity.
    cycle(1, 32'hFFFF_FFFF, 5'd3, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h0000_0000, 5'd7, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h0000_0001, 5'd9, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);

    // Fill to DEPTH with the consumer stalled, offer one more, then drain.
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, 32'h1000_0000 + i, 5'(i + 1), 0, 0);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1, 0);

    // Two entries, then ten cycles of simultaneous push and pop.
    cycle(1, 32'hA5A5_0001, 5'd1, 0, 0);
    cycle(1, 32'hA5A5_0002, 5'd2, 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 32'hC000_0000 + i, 5'(i + 10), 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

    // Three entries, then flush while another result is offered.
    for (int i = 0; i < 3; i++) cycle(1, 32'hF1F1_0000 + i, 5'(i), 0, 0);
    cycle(1, 32'hDEAD_BEEF, 5'd31, 0, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'h1234_5678, 5'd4, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rz;
      rz = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      cycle($urandom_range(0, 3) != 0, rz, 5'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 40) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1, 0);

    // Reset pulled low between edges while draining a partly full buffer.
    for (int i = 0; i < 3; i++) cycle(1, 32'h7777_0000 + i, 5'(i + 20), 0, 0);
    cycle(0, 0, 0, 1, 0);
    #2;
    q.delete();
    exp_now = 0;
    rdy_exp = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_z",     32'(out_z),     32'd0);
    chk("async_rst_count",     32'(count),     32'd0);
    chk("async_rst_in_ready",  32'(in_ready),  32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cycle(1, 32'h0F0F_0F0F, 5'd6, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_buf.md
ALU_RESULT_BUF -- requirements
Module: alu_result_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries buffered; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-005 SHALL have port in_valid  input  1  upstream logic-unit result Z is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a result this cycle.
REQ-007 SHALL have port in_z  input  32  logic-unit result, declared [0:31], bit 0 = MSB.
REQ-008 SHALL have port in_dest  input  5  destination register tag, declared [0:4].
REQ-009 SHALL have port out_valid  output  1  head entry is valid.
REQ-010 SHALL have port out_ready  input  1  writeback consumes head entry this cycle.
REQ-011 SHALL have port out_z  output  32  head result, declared [0:31].
REQ-012 SHALL have port out_dest  output  5  head destination tag, declared [0:4].
REQ-013 SHALL have port out_zero  output  1  1 when out_z is all zeros.
REQ-014 SHALL have port out_par  output  1  even-parity bit of out_z (see Configuration).
REQ-015 SHALL have port count  output  4  number of occupied entries, 0..DEPTH.

Function
REQ-016 SHALL implement a circular FIFO of DEPTH entries, each holding {z, dest, zero, par}, with read and write pointers wrapping from DEPTH-1 to 0.
REQ-017 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-018 SHALL drive in_ready = (count < DEPTH), independent of out_ready; no same-cycle pass-through when full.
REQ-019 SHALL drive out_valid = (count != 0); out_z/out_dest/out_zero/out_par SHALL come from registered storage only (no combinational path from in_* to out_*).
REQ-020 SHALL give latency exactly 1 cycle: result pushed at edge N is visible on out_* after edge N when the FIFO was empty.
REQ-021 SHALL compute zero and par at push time from in_z and store them with the entry.
REQ-022 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (legal whenever 0 < count < DEPTH).
REQ-023 SHALL keep out_* stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, on flush=1, set count and both pointers to 0 at the next edge; flush SHALL override push and pop in that cycle, and the pushed result SHALL be discarded.
REQ-025 SHALL hold out_z, out_dest, out_zero, out_par at 0 whenever count = 0.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force count=0, pointers=0, out_valid=0, in_ready=0, out_z=0, out_dest=0, out_zero=0, out_par=0.
REQ-027 SHALL assert in_ready=1 on the first rising clk edge after rst_n deasserts; a reset mid-transfer SHALL discard all entries.

Configuration
REQ-028 SHALL, with macro ALU_RESULT_PARITY_EN defined, generate and store par = XOR of in_z[0:31] and drive it on out_par.
REQ-029 SHALL, without ALU_RESULT_PARITY_EN, omit parity storage and tie out_par to 0; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, push in_z=32'hFFFFFFFF dest=5'd3 -> next cycle out_valid=1, out_z=FFFFFFFF, out_zero=0, out_par=0, count=1.
REQ-031 SHALL cover: push 32'h00000000 -> out_zero=1; push 32'h00000001 with ALU_RESULT_PARITY_EN -> out_par=1, without -> out_par=0.
REQ-032 SHALL cover: out_ready=0, push 4 results (DEPTH=4) -> count=4, in_ready=0, 5th in_valid ignored; then out_ready=1 -> results drain in push order, one per cycle.
REQ-033 SHALL cover: count=2, simultaneous push and pop for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-034 SHALL cover: count=3 with in_valid=1 and flush=1 -> next cycle count=0, out_valid=0, out_z=0.
REQ-035 SHALL cover: rst_n pulled low mid-drain between edges -> outputs 0 immediately, before the next clk edge.
